// File: rtl/ld_hazard_unit.sv
// ld_hazard_unit
//
// Load-use and memory-wait hazard controller for the 5-stage pipeline. It sits
// beside the ID/EX/MEM pipeline registers and decides, each cycle, whether to
// stall the front end, bubble ID/EX, or freeze the whole pipe for a slow memory
// access. It also keeps debug-visible counters, a timeout flag and a small state
// register.
//
// Parameters
//   AW          register address width
//   LOAD_LAT    bubbles between a load and a dependent instruction (1..3)
//   CNT_W       width of each saturating stall counter
//   MEM_TIMEOUT consecutive memory-wait cycles that raise mem_timeout
//
// Ports
//   clk, rst                  rising-edge clock, synchronous active-high reset
//   id_valid                  ID holds a real instruction
//   id_rs, id_rt              ID source register fields
//   id_use_rs, id_use_rt      ID instruction really reads rs / rt
//   ex_valid, ex_mem_read     EX holds a valid load
//   ex_rt                     destination of the EX load
//   mem_req, mem_ready        MEM access in flight / completes this cycle
//   flush                     control redirect, ID instruction is wrong-path
//   pc_stall, if_id_stall     hold PC and IF/ID
//   id_ex_flush               bubble into ID/EX
//   ex_mem_stall              hold ID/EX and EX/MEM
//   mem_wb_flush              bubble into MEM/WB
//   state                     0 RUN, 1 LU_STALL, 2 MEM_WAIT (registered)
//   lu_stall_cnt              saturating count of load-use stall cycles
//   mem_stall_cnt             saturating count of memory-wait cycles
//   mem_timeout               sticky, set after MEM_TIMEOUT waiting cycles

module ld_hazard_unit #(
    parameter int unsigned AW          = 5,
    parameter int unsigned LOAD_LAT    = 1,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [AW-1:0]    ex_rt,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             flush,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mem_stall_cnt,
    output logic             mem_timeout
);

    // The shadow pipe has LOAD_LAT-1 entries; one dummy entry is kept when
    // LOAD_LAT = 1 so the arrays stay legal, and it is tied invalid.
    localparam int unsigned PipeDepth = (LOAD_LAT > 1) ? LOAD_LAT - 1 : 1;
    localparam int unsigned TmoW      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StRun     = 2'd0,
        StLuStall = 2'd1,
        StMemWait = 2'd2
    } state_e;

    logic                 memwait;
    logic                 ex_load;
    logic                 rs_hit;
    logic                 rt_hit;
    logic                 rs_match;
    logic                 rt_match;
    logic                 luhaz;

    logic [PipeDepth-1:0] pipe_vld_q;
    logic [AW-1:0]        pipe_dst_q [PipeDepth];

    state_e               state_q;
    state_e               state_d;
    logic [CNT_W-1:0]     lu_cnt_q;
    logic [CNT_W-1:0]     lu_cnt_d;
    logic [CNT_W-1:0]     mem_cnt_q;
    logic [CNT_W-1:0]     mem_cnt_d;
    logic [TmoW-1:0]      tmo_cnt_q;
    logic [TmoW-1:0]      tmo_cnt_d;
    logic                 tmo_q;
    logic                 tmo_d;

    assign memwait = mem_req & ~mem_ready;

    // A load in EX always advances (ID/EX bubbles only affect the slot behind
    // it), so the load entering the shadow pipe is just the EX load itself.
    assign ex_load = ex_valid & ex_mem_read;

    // ------------------------------------------------------------------------
    // Shadow pipe: remembers loads that have left EX but whose data is not yet
    // forwardable. It advances with the pipeline and freezes on memory wait so
    // that pending load-use bubbles are neither lost nor duplicated.
    // ------------------------------------------------------------------------
    if (LOAD_LAT > 1) begin : g_pipe
        logic [PipeDepth-1:0] pipe_vld_d;
        logic [AW-1:0]        pipe_dst_d [PipeDepth];

        always_comb begin
            pipe_vld_d = pipe_vld_q;
            pipe_dst_d = pipe_dst_q;
            if (!memwait) begin
                pipe_vld_d[0] = ex_load;
                pipe_dst_d[0] = ex_rt;
                for (int unsigned k = 1; k < PipeDepth; k++) begin
                    pipe_vld_d[k] = pipe_vld_q[k-1];
                    pipe_dst_d[k] = pipe_dst_q[k-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_vld_q <= '0;
            end else begin
                pipe_vld_q <= pipe_vld_d;
            end
            // Destinations are only meaningful under their valid bit.
            pipe_dst_q <= pipe_dst_d;
        end
    end else begin : g_no_pipe
        assign pipe_vld_q    = '0;
        assign pipe_dst_q[0] = '0;
    end

    // ------------------------------------------------------------------------
    // Source matching against every candidate destination
    // ------------------------------------------------------------------------
    always_comb begin
        rs_hit = ex_load && (ex_rt == id_rs);
        rt_hit = ex_load && (ex_rt == id_rt);
        for (int unsigned k = 0; k < PipeDepth; k++) begin
            if (pipe_vld_q[k] && (pipe_dst_q[k] == id_rs)) begin
                rs_hit = 1'b1;
            end
            if (pipe_vld_q[k] && (pipe_dst_q[k] == id_rt)) begin
                rt_hit = 1'b1;
            end
        end
    end

    // Register 0 is hard-wired, so it never carries a dependency.
    assign rs_match = id_valid & id_use_rs & (id_rs != '0) & rs_hit;
    assign rt_match = id_valid & id_use_rt & (id_rt != '0) & rt_hit;

    // A wrong-path instruction cannot be dependent, and a memory wait already
    // freezes everything.
    assign luhaz = (rs_match | rt_match) & ~flush & ~memwait;

    // ------------------------------------------------------------------------
    // Pipeline control outputs, priority memwait > flush > luhaz
    // ------------------------------------------------------------------------
    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        mem_wb_flush = 1'b0;
        if (rst) begin
            // all controls idle while reset is asserted
        end else if (memwait) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            ex_mem_stall = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (flush) begin
            id_ex_flush  = 1'b1;
        end else if (luhaz) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_flush  = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Debug state register: records this cycle's decision
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = StRun;
        if (memwait) begin
            state_d = StMemWait;
        end else if (luhaz) begin
            state_d = StLuStall;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    // ------------------------------------------------------------------------
    // Saturating stall counters
    // ------------------------------------------------------------------------
    always_comb begin
        lu_cnt_d  = lu_cnt_q;
        mem_cnt_d = mem_cnt_q;
        if (luhaz && (lu_cnt_q != '1)) begin
            lu_cnt_d = lu_cnt_q + CNT_W'(1);
        end
        if (memwait && (mem_cnt_q != '1)) begin
            mem_cnt_d = mem_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lu_cnt_q  <= '0;
            mem_cnt_q <= '0;
        end else begin
            lu_cnt_q  <= lu_cnt_d;
            mem_cnt_q <= mem_cnt_d;
        end
    end

    assign lu_stall_cnt  = lu_cnt_q;
    assign mem_stall_cnt = mem_cnt_q;

    // ------------------------------------------------------------------------
    // Memory timeout: counts consecutive wait cycles; the flag fires on the
    // MEM_TIMEOUT-th waiting cycle and stays until reset. The run counter
    // holds at its last value so it cannot wrap during a very long wait.
    // ------------------------------------------------------------------------
    always_comb begin
        tmo_cnt_d = '0;
        if (memwait) begin
            tmo_cnt_d = (tmo_cnt_q == TmoLast) ? tmo_cnt_q : tmo_cnt_q + TmoW'(1);
        end
        tmo_d = tmo_q | (memwait & (tmo_cnt_q == TmoLast));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
        end
    end

    assign mem_timeout = tmo_q;

endmodule
